// File: rtl/rf_scan_pkg.sv
// Shared constants and state encoding for the register-file scanner.
// Defaults match the 3-read/1-write register file geometry.
package rf_scan_pkg;

   localparam int WORD_DEF  = 32;
   localparam int ARRAY_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      FIN  = 2'd3
   } scan_state_e;

endpackage

// File: rtl/rf_scan_addr_gen.sv
// Read-address generator for the scanner: holds ra, wraps modulo 2**ARRAY,
// and flags when ra has reached the latched last address.
module rf_scan_addr_gen
   import rf_scan_pkg::*;
#(
   parameter int ARRAY = ARRAY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [ARRAY-1:0] first,
   input  logic [ARRAY-1:0] last,
   output logic [ARRAY-1:0] ra,
   output logic             is_last
);

   logic [ARRAY-1:0] last_q;

   // ra doubles as the latched first address; only the end point needs its own register
   always_ff @(posedge clk) begin
      if (!rst) begin
         ra     <= '0;
         last_q <= '0;
      end else if (load) begin
         ra     <= first;
         last_q <= last;
      end else if (step) begin
         ra     <= ra + ARRAY'(1);
      end
   end

   assign is_last = (ra == last_q);

endmodule

// File: rtl/rf_scanner.sv
// Walks an address range of the register file through its debug read port and
// streams (address, data) pairs. Define RF_SCAN_CHECKSUM_EN to add the csum output.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// READ  | ra stable for one cycle, rd captured at the end of it
// HOLD  | word presented on the stream until accepted
// FIN   | one-cycle done pulse after the last word was accepted
module rf_scanner
   import rf_scan_pkg::*;
#(
   parameter int WORD  = WORD_DEF,
   parameter int ARRAY = ARRAY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [ARRAY-1:0] first_addr,
   input  logic [ARRAY-1:0] last_addr,
   output logic [ARRAY-1:0] ra,
   input  logic [WORD-1:0]  rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ARRAY-1:0] out_addr,
   output logic [WORD-1:0]  out_data,
   output logic             busy,
   output logic             done
`ifdef RF_SCAN_CHECKSUM_EN
   ,
   output logic [WORD-1:0]  csum
`endif
);

   scan_state_e state_q;
   scan_state_e state_d;

   logic accept;
   logic hs;
   logic is_last;
   logic step;

   assign accept = (state_q == IDLE) && start && !abort;
   assign hs     = (state_q == HOLD) && out_ready;
   assign step   = hs && !is_last && !abort;

   rf_scan_addr_gen #(
      .ARRAY (ARRAY)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (step),
      .first   (first_addr),
      .last    (last_addr),
      .ra      (ra),
      .is_last (is_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = READ;
         READ: state_d = abort ? IDLE : HOLD;
         HOLD: begin
            // a word accepted alongside abort is delivered, but the scan still ends
            if (abort)        state_d = IDLE;
            else if (hs)      state_d = is_last ? FIN : READ;
         end
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      out_valid = (state_q == HOLD);
      done      = (state_q == FIN) && !abort;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_addr <= '0;
         out_data <= '0;
      end else if ((state_q == READ) && !abort) begin
         out_addr <= ra;
         out_data <= rd;
      end
   end

`ifdef RF_SCAN_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         csum <= '0;
      end else if (accept) begin
         csum <= '0;
      end else if (hs) begin
         csum <= csum ^ out_data;
      end
   end
`endif

endmodule

// File: tb/tb_rf_scanner.sv
// Directed bench for rf_scanner: a register-file model drives rd, and a
// queue of expected (address, data) pairs is checked at every handshake.
module tb_rf_scanner;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  first_addr = '0;
   logic [4:0]  last_addr = '0;
   logic [4:0]  ra;
   logic [31:0] rd;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
`ifdef RF_SCAN_CHECKSUM_EN
   logic [31:0] csum;
`endif

   logic [31:0] regs [32];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_hs = 0;
   int ndone = 0;
   int nstall = 0;

   word_t expq [$];
   int    got_addr [$];
   int    got_data [$];

   logic        stall_prev = 1'b0;
   logic [4:0]  prev_addr = '0;
   logic [31:0] prev_data = '0;

   always #5 clk = ~clk;

   assign rd = (ra == 5'd0) ? 32'd0 : regs[ra];

   rf_scanner dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .ra         (ra),
      .rd         (rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done)
`ifdef RF_SCAN_CHECKSUM_EN
      ,
      .csum       (csum)
`endif
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: the scan delivers first, first+1, ... (mod 32) through last, data from the file
   task automatic push_scan(input logic [4:0] f, input logic [4:0] l);
      logic [4:0] a;
      word_t w;
      a = f;
      forever begin
         w.a = a;
         w.d = (a == 5'd0) ? 32'd0 : regs[a];
         expq.push_back(w);
         if (a == l) break;
         a = a + 5'd1;
      end
   endtask

   always @(negedge clk) begin
      word_t e;
      cyc++;
      if (rst) begin
         if (stall_prev && out_valid) begin
            chk("stall_addr_stable", int'(out_addr), int'(prev_addr));
            chk("stall_data_stable", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_word", int'(out_addr), -1);
            end else begin
               e = expq.pop_front();
               chk("word_addr", int'(out_addr), int'(e.a));
               chk("word_data", out_data, e.d);
            end
            got_addr.push_back(int'(out_addr));
            got_data.push_back(out_data);
            last_hs = cyc;
         end
         if (out_valid && !out_ready) nstall++;
         stall_prev = out_valid && !out_ready;
         prev_addr  = out_addr;
         prev_data  = out_data;
         if (done) begin
            ndone++;
            chk("done_latency", cyc - last_hs, 1);
            chk("done_words_left", expq.size(), 0);
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ra"}, int'(ra), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_addr"}, int'(out_addr), 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic do_start(input logic [4:0] f, input logic [4:0] l);
      push_scan(f, l);
      got_addr.delete();
      got_data.delete();
      @(posedge clk); #1;
      start = 1'b1; first_addr = f; last_addr = l;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("lat_valid_c1", int'(out_valid), 0);
      chk("lat_busy_c1", int'(busy), 1);
      @(negedge clk);
      chk("lat_valid_c2", int'(out_valid), 1);
      chk("lat_addr_c2", int'(out_addr), int'(f));
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      chk("done_seen", int'(done), 1);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_after_done", int'(busy), 0);
   endtask

   task automatic wait_word(input logic [4:0] a, input int budget);
      int n;
      n = 0;
      while (!(out_valid && out_addr == a) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("word_reached", int'(out_valid && out_addr == a), 1);
   endtask

   initial begin
      int nd;
      for (int k = 0; k < 32; k++) regs[k] = 32'(k * 3);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // full dump 0..31
      do_start(5'd0, 5'd31);
      wait_done(200);
      chk("full_count", got_addr.size(), 32);
      chk("full_addr31", got_addr[31], 31);
      chk("full_data31", got_data[31], 93);
      chk("full_data10", got_data[10], 30);
      chk("full_ndone", ndone, 1);

      // wrap range 30..1
      do_start(5'd30, 5'd1);
      wait_done(50);
      chk("wrap_count", got_addr.size(), 4);
      chk("wrap_a0", got_addr[0], 30);
      chk("wrap_a1", got_addr[1], 31);
      chk("wrap_a2", got_addr[2], 0);
      chk("wrap_a3", got_addr[3], 1);
      repeat (10) @(negedge clk);
      chk("wrap_single_done", ndone, 2);

      // backpressure on word 2 for 5 cycles
      nstall = 0;
      do_start(5'd0, 5'd5);
      wait_word(5'd1, 20);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      repeat (5) @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(50);
      chk("bp_stalls", nstall, 5);
      chk("bp_count", got_addr.size(), 6);
      chk("bp_a2", got_addr[2], 2);
      chk("bp_a3", got_addr[3], 3);

      // abort while word 3 is held
      nd = ndone;
      do_start(5'd0, 5'd10);
      wait_word(5'd2, 20);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_hold", int'(out_valid && out_addr == 5'd3), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      expq.delete();
      @(negedge clk);
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_count", got_addr.size(), 3);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_done", ndone, nd);
      do_start(5'd4, 5'd4);
      wait_done(20);
      chk("single_count", got_addr.size(), 1);
      chk("single_addr", got_addr[0], 4);
      chk("single_data", got_data[0], 12);

      // reset in the middle of a scan
      nd = ndone;
      do_start(5'd0, 5'd10);
      wait_word(5'd5, 30);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      expq.delete();
      @(negedge clk);
      check_reset_vals("midrst");
      repeat (5) @(negedge clk);
      chk("midrst_no_done", ndone, nd);

      // start and abort together in IDLE
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; first_addr = 5'd3; last_addr = 5'd4;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("sa_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("sa_busy_later", int'(busy), 0);
      chk("sa_valid", int'(out_valid), 0);

`ifdef RF_SCAN_CHECKSUM_EN
      regs[1] = 32'h0000_00F0;
      regs[2] = 32'h0000_000F;
      regs[3] = 32'h0000_00FF;
      do_start(5'd1, 5'd3);
      wait_done(30);
      chk("csum_1_3", csum, 32'h0);
      do_start(5'd1, 5'd2);
      wait_done(30);
      chk("csum_1_2", csum, 32'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rf_scanner.md
Name: rf_scanner

Overview:
- Initiator-side reader for the 3-read/1-write register file.
- Drives the file's debug read port (ra2/rd2) and walks an address range.
- Emits each (address, data) pair as a valid/ready stream to the debug/display path (seven-segment or UART dumper).
- Read-only: never touches we/wa/wd.

Parameters:
- WORD, 32, data width of one register (matches register file WORD).
- ARRAY, 5, address width; register file depth is 2**ARRAY.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- abort  input  1  stop the current scan; return to IDLE next cycle.
- first_addr  input  ARRAY  first address of range; latched on accepted start.
- last_addr  input  ARRAY  last address of range (inclusive); latched on accepted start.
- ra  output  ARRAY  read address to register file ra2; registered.
- rd  input  WORD  read data from register file rd2; combinational with ra.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_addr  output  ARRAY  address of the current stream word.
- out_data  output  WORD  register contents captured for out_addr.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; ra=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0; latched range cleared to 0. Reset mid-scan discards all progress; no done pulse.
- States: IDLE, READ, HOLD, FIN.
- IDLE:
  - start=1: latch first_addr/last_addr, ra<=first_addr, go READ.
  - start and abort together: abort wins; stay IDLE.
- READ (one cycle, ra stable):
  - Capture out_data<=rd, out_addr<=ra, out_valid<=1, go HOLD.
  - Latency is start→first out_valid = 2 cycles.
- HOLD:
  - out_valid=1; out_addr/out_data held stable until the handshake completes.
  - Handshake completes and out_addr==last: out_valid<=0, go FIN.
  - Handshake completes otherwise: ra<=ra+1 (mod 2**ARRAY), out_valid<=0, go READ.
  - Throughput is one word per 2 cycles with out_ready tied high.
- FIN: done<=1 for exactly one cycle, busy<=0, go IDLE.
- Range and wrap:
  - Address arithmetic is ARRAY bits, modulo 2**ARRAY.
  - last<first wraps through 2**ARRAY-1 to 0, e.g. first=30, last=1 gives 30,31,0,1.
  - first==last gives exactly one word.
  - first=0, last=2**ARRAY-1 gives a full dump of 2**ARRAY words.
- abort:
  - In READ/HOLD/FIN: next state IDLE, out_valid<=0, no done pulse.
  - abort in the same cycle as a HOLD handshake: the word counts as delivered, but the scan still stops.
- start while busy: ignored.
- Register file writes during a scan: each word reflects rd in its READ cycle; no snapshot coherency is provided.
- Address 0 always reads 0 (file property); the scanner does not special-case it.

Optional Feature:
- Macro RF_SCAN_CHECKSUM_EN.
- Defined:
  - Extra output csum [WORD-1:0], reset 0, cleared on accepted start.
  - csum XOR-accumulates out_data on each completed handshake.
  - Final value is valid in the FIN/done cycle and holds until the next start or reset.
- Undefined: port absent, no accumulator logic.

Decomposition:
- Package rf_scan_pkg:
  - state enum (IDLE, READ, HOLD, FIN) as 2-bit localparams.
  - Default WORD/ARRAY constants shared with the register file.
- One natural sub-module, rf_scan_addr_gen:
  - Holds ra, performs modulo increment, compares against latched last.
  - Outputs the is_last flag.

Test Plan:
- Reset then full dump: preload reg k = k*3, first=0, last=31, out_ready=1 → 32 words with out_addr 0..31, out_data 0,3,...,93; done one cycle after word 31 is accepted; busy low after.
- Wrap range: first=30, last=1 → out_addr sequence 30,31,0,1, then done; no 2nd pulse.
- Backpressure: out_ready low 5 cycles on word 2 → out_valid/out_addr/out_data stable for all 5 cycles; no word skipped or duplicated.
- Abort in HOLD at word 3 of 0..10 → out_valid=0 next cycle, busy=0, no done; a subsequent start=1 (first=4, last=4) yields one word at address 4.
- Reset mid-scan (rst=0 for 1 cycle at word 5) → all outputs return to reset values; start/abort together in IDLE → stays IDLE.
- RF_SCAN_CHECKSUM_EN: regs 1..3 = 0xF0, 0x0F, 0xFF, range 1..3 → csum = 0x00 at done; range 1..2 → csum = 0xFF.
